// File: rtl/arb_rr_2to1_pkg.sv
// Shared definitions for the 2:1 round-robin req/ack arbiter.
// Channel field width defaults and FSM state encodings.
package arb_rr_2to1_pkg;

  localparam int NS_ADDRESS_SIZE = 8;
  localparam int NS_DATA_SIZE    = 16;
  localparam int NS_REDUN_SIZE   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/arb_rr_2to1_pick.sv
// Round-robin pick between two eligible requesters.
// Pointer breaks the tie; a lone eligible input always wins.
module rr_pick_2
  import arb_rr_2to1_pkg::*;
(
  input  logic [1:0] i_elig,
  input  logic       i_ptr,
  output logic       o_win,
  output logic       o_valid
);

  always_comb begin
    o_win = 1'b0;
    unique case (1'b1)
      &i_elig:                o_win = i_ptr;
      i_elig[1] & ~i_elig[0]: o_win = 1'b1;
      default:                o_win = 1'b0;
    endcase
  end

  assign o_valid = |i_elig;

endmodule

// File: rtl/arb_rr_2to1.sv
// 2:1 round-robin arbiter over 4-phase req/ack channels.
// One buffered message in flight; grants only from IDLE.
module arb_rr_2to1
  import arb_rr_2to1_pkg::*;
#(
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int RSZ = NS_REDUN_SIZE,
  parameter int CSZ = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [ASZ-1:0] i0_src,
  input  logic [ASZ-1:0] i0_dst,
  input  logic [DSZ-1:0] i0_dat,
  input  logic [RSZ-1:0] i0_red,
  input  logic           i0_req,
  output logic           i0_ack,
  input  logic [ASZ-1:0] i1_src,
  input  logic [ASZ-1:0] i1_dst,
  input  logic [DSZ-1:0] i1_dat,
  input  logic [RSZ-1:0] i1_red,
  input  logic           i1_req,
  output logic           i1_ack,
  output logic [ASZ-1:0] o0_src,
  output logic [ASZ-1:0] o0_dst,
  output logic [DSZ-1:0] o0_dat,
  output logic [RSZ-1:0] o0_red,
  output logic           o0_req,
  input  logic           o0_ack,
  output logic           o_busy,
  output logic           o_last_gnt,
  output logic [CSZ-1:0] o_gnt_cnt0,
  output logic [CSZ-1:0] o_gnt_cnt1,
  output logic           o_proto_err
);

  state_e         state_q, state_d;
  logic [1:0]     rst_sync;
  logic [1:0]     req, ack_q, elig;
  logic           run, win, gnt_v, grant;
  logic           ptr_q, last_q, req_q, err_q;
  logic [ASZ-1:0] src_q, dst_q;
  logic [DSZ-1:0] dat_q;
  logic [RSZ-1:0] red_q;
  logic [CSZ-1:0] cnt0_q, cnt1_q;

  // Reset asserts at once but releases two edges later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run   = rst_sync[1];
  assign req   = {i1_req, i0_req};
  assign elig  = req & ~ack_q;
  assign grant = (state_q == ST_IDLE) & run & gnt_v;

  rr_pick_2 u_pick (
    .i_elig  (elig),
    .i_ptr   (ptr_q),
    .o_win   (win),
    .o_valid (gnt_v)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (grant) state_d = ST_XFER;
      ST_XFER:  if (!req_q && !ack_q[last_q]) state_d = ST_DRAIN;
      ST_DRAIN: if (!o0_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      src_q  <= '0;
      dst_q  <= '0;
      dat_q  <= '0;
      red_q  <= '0;
      req_q  <= 1'b0;
      ack_q  <= 2'b00;
      ptr_q  <= 1'b0;
      last_q <= 1'b0;
      cnt0_q <= '0;
      cnt1_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (grant) begin
        src_q      <= win ? i1_src : i0_src;
        dst_q      <= win ? i1_dst : i0_dst;
        dat_q      <= win ? i1_dat : i0_dat;
        red_q      <= win ? i1_red : i0_red;
        req_q      <= 1'b1;
        ack_q[win] <= 1'b1;
        ptr_q      <= ~win;
        last_q     <= win;
        if (win) cnt1_q <= cnt1_q + 1'b1;
        else     cnt0_q <= cnt0_q + 1'b1;
      end else if (state_q == ST_XFER) begin
        if (o0_ack)       req_q         <= 1'b0;
        if (!req[last_q]) ack_q[last_q] <= 1'b0;
      end
      // Sink ack with nothing pending, or a winner without req.
      if ((state_q == ST_IDLE && o0_ack && !req_q) ||
          (grant && !req[win]))
        err_q <= 1'b1;
    end
  end

  assign o0_src      = src_q;
  assign o0_dst      = dst_q;
  assign o0_dat      = dat_q;
  assign o0_red      = red_q;
  assign o0_req      = req_q;
  assign i0_ack      = ack_q[0];
  assign i1_ack      = ack_q[1];
  assign o_busy      = (state_q != ST_IDLE);
  assign o_last_gnt  = last_q;
  assign o_gnt_cnt0  = cnt0_q;
  assign o_gnt_cnt1  = cnt1_q;
  assign o_proto_err = err_q;

endmodule
